// File: rtl/disp_src_scan.sv
// Display-source selector and auto-scanner feeding the seven-segment driver.
// Channel 0 is a CPU-written register; channels 1..NCH-1 are live debug taps.
module disp_src_scan #(
    parameter int          WIDTH    = 32,
    parameter int          NCH      = 8,
    parameter int          SEL_W    = 3,
    parameter int          SCAN_DIV = 50000000,
    parameter logic [31:0] RST_VAL  = 32'hAA5555AA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_we,
    input  logic [WIDTH-1:0]         cpu_data,
    input  logic [SEL_W-1:0]         test_sel,
    input  logic [(NCH-1)*WIDTH-1:0] test_data,
    input  logic                     auto_en,
    input  logic                     freeze,
    output logic [WIDTH-1:0]         disp_num,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     ch_tick
);

    localparam int                CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [WIDTH-1:0]  RST_W    = WIDTH'(RST_VAL);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NCH - 1);

    logic [WIDTH-1:0] cpu_reg, cpu_reg_nxt;
    logic [WIDTH-1:0] disp_nxt;
    logic [SEL_W-1:0] cur_nxt, adv_ch;
    logic [CNT_W-1:0] div_cnt, div_nxt;
    logic             tick_nxt;

    logic [WIDTH-1:0] chans [NCH];
    logic [WIDTH-1:0] sel_val, cur_val, adv_val;
    logic             sel_ok;

    // A CPU write is forwarded so channel 0 shows the new value on the same edge.
    always_comb begin
        chans[0] = cpu_we ? cpu_data : cpu_reg;
        for (int k = 1; k < NCH; k++)
            chans[k] = test_data[k*WIDTH-1 -: WIDTH];
    end

    assign adv_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);

    // Out-of-range manual selects leave sel_ok low, which makes the display hold.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_val = '0;
        cur_val = '0;
        adv_val = '0;
        sel_ok  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (test_sel == SEL_W'(k)) begin
                sel_val = chans[k];
                sel_ok  = 1'b1;
            end
            if (cur_ch == SEL_W'(k)) cur_val = chans[k];
            if (adv_ch == SEL_W'(k)) adv_val = chans[k];
        end
    end

    always_comb begin
        cpu_reg_nxt = cpu_we ? cpu_data : cpu_reg;
        disp_nxt    = disp_num;
        cur_nxt     = cur_ch;
        div_nxt     = div_cnt;
        tick_nxt    = 1'b0;
        if (freeze) begin
            // display, index and prescaler all hold; only cpu_reg moves
        end else if (auto_en) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt  = '0;
                cur_nxt  = adv_ch;
                tick_nxt = 1'b1;
                disp_nxt = adv_val;
            end else begin
                div_nxt  = div_cnt + CNT_W'(1);
                disp_nxt = cur_val;
            end
        end else begin
            div_nxt = '0;
            if (sel_ok) begin
                cur_nxt  = test_sel;
                disp_nxt = sel_val;
            end
        end
    end

    // The output path is timed on the falling edge of the system clock.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cpu_reg  <= RST_W;
            disp_num <= RST_W;
            cur_ch   <= '0;
            div_cnt  <= '0;
            ch_tick  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
            cpu_reg  <= cpu_reg_nxt;
            disp_num <= disp_nxt;
            cur_ch   <= cur_nxt;
            div_cnt  <= div_nxt;
            ch_tick  <= tick_nxt;
        end
    end

endmodule

// File: doc/disp_src_scan.md
Name: disp_src_scan

Overview:
- Parametrised display-source selector and scanner for the seven-segment output path.
- Sits between the CPU GPIO write port, NCH-1 debug/test data taps, and the seven-segment driver.
- Manual mode: a channel select chooses which value reaches the display.
- Auto mode: a prescaled counter rotates through all channels.
- Adds freeze, live channel index and channel-change strobe.

Parameters:
- WIDTH, 32, data width of every channel and of disp_num
- NCH, 8, number of channels; channel 0 = CPU-written register, channels 1..NCH-1 = test taps
- SEL_W, 3, width of channel select/index; NCH <= 2**SEL_W
- SCAN_DIV, 50000000, clk cycles per channel in auto mode; >= 1
- RST_VAL, 32'hAA5555AA, reset value of disp_num and cpu_reg (truncated/zero-extended to WIDTH)

Ports:
- clk  in  1  system clock; all state updates on the falling edge
- rst  in  1  asynchronous, active-high reset
- cpu_we  in  1  CPU write strobe for channel-0 register (GPIO write enable)
- cpu_data  in  WIDTH  CPU write data
- test_sel  in  SEL_W  manual channel select
- test_data  in  (NCH-1)*WIDTH  flattened taps; channel k = test_data[k*WIDTH-1 -: WIDTH]
- auto_en  in  1  1 = auto-scan mode, 0 = manual
- freeze  in  1  hold display, index and prescaler
- disp_num  out  WIDTH  registered display value
- cur_ch  out  SEL_W  registered index of the channel currently shown
- ch_tick  out  1  one-cycle pulse when cur_ch advances in auto mode

Behaviour:
- Reset (async, rst=1): disp_num=RST_VAL, cpu_reg=RST_VAL, cur_ch=0, div_cnt=0, ch_tick=0. Reset asserted mid-scan aborts immediately; the scan restarts from channel 0 after release.
- All registers update on the falling edge of clk.
- cpu_reg:
  - loads cpu_data on any edge with cpu_we=1, regardless of mode or freeze.
  - chan(0) = cpu_we ? cpu_data : cpu_reg, so a write is visible on disp_num at the same edge.
- chan(k), k=1..NCH-1: the corresponding test_data slice, sampled live each edge.
- Priority per edge: rst > freeze > auto_en > manual.
- freeze=1:
  - disp_num, cur_ch and div_cnt hold; ch_tick=0.
  - cpu_reg still captures writes.
  - After freeze releases, disp_num shows chan(cur_ch) on the next edge.
- Manual (auto_en=0, freeze=0):
  - if test_sel < NCH: cur_ch<=test_sel, disp_num<=chan(test_sel).
  - if test_sel >= NCH: disp_num and cur_ch hold.
  - div_cnt<=0, ch_tick=0.
  - Latency: one falling edge from select/data change to disp_num.
- Auto (auto_en=1, freeze=0):
  - div_cnt increments each edge.
  - When div_cnt==SCAN_DIV-1: div_cnt<=0; cur_ch<=(cur_ch==NCH-1)?0:cur_ch+1; ch_tick<=1; disp_num<=chan(new index).
  - Otherwise: ch_tick<=0; disp_num<=chan(cur_ch), tracking live data.
  - test_sel is ignored.
  - SCAN_DIV=1 advances every edge.
- Mode entry/exit:
  - 0->1 on auto_en: scanning continues from the current cur_ch with div_cnt=0 (cleared in manual).
  - 1->0: the manual rule applies from the next edge.
- cpu_we together with display of channel 0 on the same edge: disp_num takes the new cpu_data.
- div_cnt width = clog2(SCAN_DIV), minimum 1; it never exceeds SCAN_DIV-1.

Test Plan:
- Reset: assert rst between edges -> disp_num=AA5555AA immediately, cur_ch=0, ch_tick=0; no clk needed.
- Manual select: test_sel=3, slice 2=32'h12345678 -> disp_num=12345678 and cur_ch=3 after 1 falling edge. Then test_sel=0, cpu_we=1, cpu_data=DEADBEEF -> disp_num=DEADBEEF on that edge. Then cpu_we=0 -> disp_num stays DEADBEEF.
- Out-of-range select: NCH=5, test_sel=6 -> disp_num and cur_ch unchanged over 10 edges.
- Auto scan: SCAN_DIV=4, NCH=8, auto_en=1 from cur_ch=6:
  - ch_tick pulses every 4th edge.
  - cur_ch sequence 7,0,1.
  - disp_num matches each channel's value; wrap 7->0 shows cpu_reg.
- Freeze: during auto scan with div_cnt=2, freeze=1 for 20 edges -> no ch_tick, disp_num constant, and a cpu_we write of 0000CAFE still lands in cpu_reg. On release, ch_tick fires after exactly 2 more edges (div_cnt 2->3 then advance).
- Reset mid-scan: auto mode at cur_ch=5, pulse rst -> disp_num=AA5555AA, cur_ch=0, then first ch_tick SCAN_DIV edges after release.
